// File: rtl/decoder_scan_ctrl.sv
// Round-robin channel scanner driving the 3-to-8 decoder select, with per-channel dwell and mask skip.
// Optional guard interval after each dwell is enabled by defining SCAN_BLANK_EN.
module decoder_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned CNT_W        = 17,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       frame_done,
    output logic       busy
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, SEEK, DWELL, BLANK} state_t;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;
`endif

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    // Both counts must be nonzero where used and fit the shared counter.
    if ((DWELL_CYCLES < 1) || (64'(DWELL_CYCLES) > (64'd1 << CNT_W))) begin : g_bad_dwell
        $error("decoder_scan_ctrl: DWELL_CYCLES out of range for CNT_W");
    end
    if (64'(BLANK_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_blank
        $error("decoder_scan_ctrl: BLANK_CYCLES out of range for CNT_W");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             first_seek, first_nxt;
    logic [2:0]       sel_nxt;
    logic             valid_nxt, fd_nxt, busy_nxt;

    logic [2:0]       origin, cand, found_idx;
    logic             found;

    // First enabled channel at or after origin, wrapping modulo 8.
    always_comb begin
        origin    = first_seek ? 3'd0 : sel + 3'd1;
        cand      = '0;
        found     = 1'b0;
        found_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = origin + 3'(i);
            if (!found && mask[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        first_nxt = first_seek;
        sel_nxt   = sel;
        valid_nxt = 1'b0;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = SEEK;
                    first_nxt = 1'b1;
                end
            end
            SEEK: begin
                if (stop || !found) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DWELL;
                    sel_nxt   = found_idx;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                    fd_nxt    = !first_seek && (found_idx <= sel);
                    first_nxt = 1'b0;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == DWELL_LAST) begin
                    cnt_nxt = '0;
`ifdef SCAN_BLANK_EN
                    state_nxt = BLANK;
`else
                    state_nxt = SEEK;
`endif
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    valid_nxt = 1'b1;
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SEEK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            first_seek <= 1'b0;
            sel        <= '0;
            sel_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            first_seek <= first_nxt;
            sel        <= sel_nxt;
            sel_valid  <= valid_nxt;
            frame_done <= fd_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed plus randomized bench for decoder_scan_ctrl against a channel-period reference model.
module tb_decoder_scan_ctrl;

    localparam int D = 4;
`ifdef SCAN_BLANK_EN
    localparam int B = 2;
`else
    localparam int B = 0;
`endif
    localparam int P = 1 + D + B;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       sel_valid, frame_done, busy;

    int total = 0;
    int bad   = 0;

    // model: position within a channel period (0 = seek, 1..D = dwell, rest = blank)
    bit m_active, m_first, m_fd;
    int m_pos, m_ch;

    decoder_scan_ctrl #(.DWELL_CYCLES(D), .CNT_W(17), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask),
        .sel(sel), .sel_valid(sel_valid), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_first = 0; m_fd = 0; m_pos = 0; m_ch = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit hit;
        m_fd = 0;
        if (!m_active) begin
            if (start && !stop) begin
                m_active = 1; m_pos = 0; m_first = 1;
            end
        end else if (stop) begin
            m_active = 0;
        end else if (m_pos == 0) begin
            hit = 0; nxt = 0;
            for (int k = 0; k < 8; k++) begin
                if (!hit && mask[((m_first ? 0 : m_ch + 1) + k) % 8]) begin
                    hit = 1;
                    nxt = ((m_first ? 0 : m_ch + 1) + k) % 8;
                end
            end
            if (!hit) m_active = 0;
            else begin
                m_fd = !m_first && (nxt <= m_ch);
                m_ch = nxt; m_first = 0; m_pos = 1;
            end
        end else begin
            m_pos = (m_pos + 1) % P;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("sel", 8'(sel), 8'(m_ch));
        chk("sel_valid", 8'(sel_valid), 8'(m_active && m_pos >= 1 && m_pos <= D));
        chk("frame_done", 8'(frame_done), 8'(m_fd));
        chk("busy", 8'(busy), 8'(m_active));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start();
        start = 1; cyc(); start = 0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 0;
        #1;
        chk({tag, "_sel"}, 8'(sel), 8'h00);
        chk({tag, "_valid"}, 8'(sel_valid), 8'h00);
        chk({tag, "_busy"}, 8'(busy), 8'h00);
        chk({tag, "_fd"}, 8'(frame_done), 8'h00);
        model_reset();
        @(negedge clk) rst_n = 1;
    endtask

    task automatic run_until_dwell_on(input int ch);
        int guard = 0;
        while (!(m_active && m_ch == ch && m_pos == 2) && guard < 200) begin
            cyc(); guard++;
        end
        chk("dwell_reached", 8'(guard < 200), 8'h01);
    endtask

    initial begin
        start = 0; stop = 0; mask = 8'hFF; rst_n = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_sel", 8'(sel), 8'h00);
        chk("rst_valid", 8'(sel_valid), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_fd", 8'(frame_done), 8'h00);
        model_reset();
        @(negedge clk) rst_n = 1;
        run(3);

        // full scan, two frames plus
        mask = 8'hFF;
        pulse_start();
        run(90);

        // sparse mask, then shrink mask while dwelling on channel 5
        stop = 1; cyc(); stop = 0;
        mask = 8'b1010_0100;
        pulse_start();
        run(40);
        run_until_dwell_on(5);
        mask = 8'h01;
        run(20);

        // single channel, then empty mask
        stop = 1; cyc(); stop = 0;
        mask = 8'b0001_0000;
        pulse_start();
        run(25);
        stop = 1; cyc(); stop = 0;
        mask = 8'h00;
        pulse_start();
        run(4);

        // stop mid-dwell on channel 3; start+stop in idle; start while busy
        mask = 8'hFF;
        pulse_start();
        run_until_dwell_on(3);
        stop = 1; cyc(); stop = 0;
        run(2);
        start = 1; stop = 1; run(3); start = 0; stop = 0;
        run(2);
        pulse_start();
        run(7);
        pulse_start();
        run(30);

        // asynchronous reset while scanning (lands in blank when that is built in)
        run_until_dwell_on(6);
        run(D);
        async_reset_check("arst");
        run(3);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0)
                mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cyc();
        end
        start = 0; stop = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
